// File: rtl/spike_pkg.sv
// Shared definitions for the spike readout blocks: default counter width,
// saturation helper and the {rate, isi} result record.
package spike_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Largest value an unsigned counter of width w can hold.
  function automatic int unsigned sat_max(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] rate;
    logic [CNT_W_DEFAULT-1:0] isi;
  } spike_result_t;

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter. The clear takes priority and lands on 0, or on 1 when
// the increment is also asserted, so a "restart counting from this event" is one cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? ONE : '0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train readout: counts spikes per programmable window, tracks the last
// inter-spike interval and publishes {rate, isi} per window on a valid/ready port.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike,
  input  logic [CNT_W-1:0] window_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] rate,
  output logic [CNT_W-1:0] isi,
  output logic             dropped
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] rate;
    logic [CNT_W-1:0] isi;
  } result_t;

  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_len_q;
  logic [CNT_W-1:0] r_last_isi;
  logic             r_valid;
  logic             r_dropped;
  result_t          r_result;

  logic [CNT_W-1:0] w_len;
  logic             w_close;
  logic             w_slot_free;
  logic [CNT_W-1:0] w_scnt;
  logic [CNT_W-1:0] w_icnt;
  logic             w_icnt_run;
  logic [CNT_W-1:0] w_isi_new;
  result_t          w_result_new;

  // On window cycle 0 the length is taken straight from the input, so L=1
  // closes in the same cycle it is latched. len 0 wraps L-1 to all-ones.
  assign w_len   = (r_wcnt == '0) ? window_len : r_len_q;
  assign w_close = (r_wcnt == (w_len - ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_len_q <= '0;
    end else begin
      if (r_wcnt == '0) r_len_q <= window_len;
      r_wcnt <= w_close ? '0 : (r_wcnt + ONE);
    end
  end

  sat_counter #(.W(CNT_W)) u_scnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_close),
    .i_inc   (spike & ~w_close),
    .o_count (w_scnt)
  );

  assign w_icnt_run = spike | (w_icnt != '0);

  sat_counter #(.W(CNT_W)) u_icnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (spike),
    .i_inc   (w_icnt_run),
    .o_count (w_icnt)
  );

  // Both the reported rate and ISI fold in a spike arriving on this very cycle.
  assign w_isi_new         = (spike && (w_icnt != '0)) ? w_icnt : r_last_isi;
  assign w_result_new.rate = (spike && (w_scnt != MAX)) ? (w_scnt + ONE) : w_scnt;
  assign w_result_new.isi  = w_isi_new;

  always_ff @(posedge clk) begin
    if (rst) r_last_isi <= '0;
    else     r_last_isi <= w_isi_new;
  end

  assign w_slot_free = ~r_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_dropped <= 1'b0;
      r_result  <= '0;
    end else if (w_close) begin
      if (w_slot_free) begin
        r_valid  <= 1'b1;
        r_result <= w_result_new;
      end else begin
        r_dropped <= 1'b1;
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign rate      = r_result.rate;
  assign isi       = r_result.isi;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: directed scenarios plus random
// traffic, compared each cycle against a spike-time based reference model.
module tb_spike_rate_decoder;
  import spike_pkg::*;

  localparam int CNT_W = 8;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             spike;
  logic [CNT_W-1:0] window_len;
  logic             out_ready;
  logic             out_valid;
  logic [CNT_W-1:0] rate;
  logic [CNT_W-1:0] isi;
  logic             dropped;

  spike_rate_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .spike      (spike),
    .window_len (window_len),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .rate       (rate),
    .isi        (isi),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: window position, spike count, and the times of the
  // most recent spikes; ISI is a plain difference of spike times.
  int            m_cyc, m_len, m_cnt, m_t, m_last_spike, m_isi;
  logic          m_valid, m_drop;
  spike_result_t m_res;

  task automatic model_reset();
    m_cyc = 0; m_len = 0; m_cnt = 0; m_t = 0;
    m_last_spike = -1; m_isi = 0;
    m_valid = 1'b0; m_drop = 1'b0; m_res = '0;
  endtask

  task automatic model_step(input logic r, input logic sp, input int wl, input logic rd);
    bit close;
    if (r) begin
      model_reset();
      return;
    end
    if (m_cyc == 0) m_len = (wl == 0) ? 256 : wl;
    if (sp) begin
      if (m_last_spike >= 0) m_isi = (m_t - m_last_spike > MAXV) ? MAXV : (m_t - m_last_spike);
      m_last_spike = m_t;
      m_cnt++;
    end
    close = (m_cyc == m_len - 1);
    if (close) begin
      if (!m_valid || rd) begin
        m_valid  = 1'b1;
        m_res.rate = 8'((m_cnt > MAXV) ? MAXV : m_cnt);
        m_res.isi  = 8'(m_isi);
      end else begin
        m_drop = 1'b1;
      end
      m_cyc = 0;
      m_cnt = 0;
    end else begin
      if (m_valid && rd) m_valid = 1'b0;
      m_cyc++;
    end
    m_t++;
  endtask

  // One clock cycle: drive on the falling edge, compare 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic sp, input int wl, input logic rd);
    @(negedge clk);
    rst = r; spike = sp; window_len = 8'(wl); out_ready = rd;
    model_step(r, sp, wl, rd);
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("dropped", {31'd0, dropped}, {31'd0, m_drop});
    if (m_valid) begin
      check("rate", {24'd0, rate}, {24'd0, m_res.rate});
      check("isi", {24'd0, isi}, {24'd0, m_res.isi});
    end
  endtask

  initial begin
    rst = 1'b1; spike = 1'b0; window_len = 8'd4; out_ready = 1'b0;
    model_reset();
    cyc(1, 0, 4, 0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_rate", {24'd0, rate}, 32'd0);
    check("reset_isi", {24'd0, isi}, 32'd0);
    check("reset_dropped", {31'd0, dropped}, 32'd0);

    // Continuous spikes, L=4
    for (int k = 0; k < 4; k++) cyc(0, 1, 4, 1);
    check("cont_valid", {31'd0, out_valid}, 32'd1);
    check("cont_rate", {24'd0, rate}, 32'd4);
    check("cont_isi", {24'd0, isi}, 32'd1);
    for (int k = 0; k < 12; k++) cyc(0, 1, 4, 1);

    // ISI and first window, L=16
    cyc(1, 0, 16, 1);
    for (int k = 0; k < 16; k++) cyc(0, k == 5, 16, 1);
    check("isi1_rate", {24'd0, rate}, 32'd1);
    check("isi1_isi", {24'd0, isi}, 32'd0);
    for (int k = 16; k < 32; k++) cyc(0, (k == 18) || (k == 25), 16, 1);
    check("isi2_rate", {24'd0, rate}, 32'd2);
    check("isi2_isi", {24'd0, isi}, 32'd7);

    // Saturation of rate and ISI with 256-cycle windows
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 256; k++) cyc(0, 1, 0, 1);
    check("sat_rate", {24'd0, rate}, 32'd255);
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 512; k++) cyc(0, (k == 0) || (k == 300), 0, 1);
    check("sat_isi", {24'd0, isi}, 32'd255);
    check("sat_isi_rate", {24'd0, rate}, 32'd1);

    // Backpressure and drop, L=4
    cyc(1, 0, 4, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 4, 0);
    check("bp_rate", {24'd0, rate}, 32'd4);
    for (int k = 0; k < 4; k++) cyc(0, 0, 4, 0);
    check("bp_dropped", {31'd0, dropped}, 32'd1);
    check("bp_rate_held", {24'd0, rate}, 32'd4);
    cyc(0, 0, 4, 1);
    check("bp_taken", {31'd0, out_valid}, 32'd0);

    // Close coincident with transfer, L=2, then mid-window length change
    cyc(1, 0, 2, 1);
    for (int k = 0; k < 12; k++) cyc(0, k[0], 2, 1);
    check("l2_valid", {31'd0, out_valid}, 32'd1);
    check("l2_rate", {24'd0, rate}, 32'd1);
    cyc(0, 1, 2, 1);
    for (int k = 0; k < 12; k++) cyc(0, k[0], 3, 1);

    // Reset in the middle of a window, L=8
    cyc(1, 0, 8, 0);
    for (int k = 0; k < 5; k++) cyc(0, (k == 0) || (k == 2) || (k == 4), 8, 0);
    cyc(1, 0, 8, 0);
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_dropped", {31'd0, dropped}, 32'd0);
    for (int k = 0; k < 8; k++) cyc(0, k == 3, 8, 1);
    check("rstmid_rate", {24'd0, rate}, 32'd1);
    check("rstmid_isi", {24'd0, isi}, 32'd0);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      int wl;
      wl = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), wl,
          ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
